// File: rtl/reg_file_mp.sv
// Purpose : parametrised register file, one write port, NUM_RD independent read ports,
//           per-entry valid tracking, synchronous clear, optional bypass / zero entry.
// Latency : reads are combinational (READ_LAT=0) or one cycle (READ_LAT=1); writes land at posedge.
// Backpressure: none; every write and read is accepted every cycle.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   we/in_sel/in_reg write enable, address, data
//   clr             synchronous clear of all entries and valid bits (wins over a write)
//   out_sel         NUM_RD packed read addresses, port p at [p*AW +: AW]
//   out_reg         NUM_RD packed read data, port p at [p*DATA_W +: DATA_W]
//   out_valid       per-port: addressed entry written since last reset/clr
//   valid_map       registered per-entry valid bits
//   wr_err          one-cycle pulse after an out-of-range write attempt
module reg_file_mp #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int NUM_RD   = 2,
    parameter int READ_LAT = 0,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0,
    localparam int AW      = (DEPTH <= 2) ? 1 : $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [AW-1:0]            in_sel,
    input  logic [DATA_W-1:0]        in_reg,
    input  logic                     clr,
    input  logic [NUM_RD*AW-1:0]     out_sel,
    output logic [NUM_RD*DATA_W-1:0] out_reg,
    output logic [NUM_RD-1:0]        out_valid,
    output logic [DEPTH-1:0]         valid_map,
    output logic                     wr_err
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  r_valid;
    logic              r_wr_err;

    logic              w_in_range;
    logic              w_zero_hit;
    logic              w_wr_ok;
    logic [DATA_W-1:0] w_raw [NUM_RD];
    logic [NUM_RD-1:0] w_rvld;

    assign w_in_range = int'(in_sel) < DEPTH;
    assign w_zero_hit = (ZERO_REG != 0) && (in_sel == '0);
    // A write that actually commits this edge; also the bypass qualifier.
    assign w_wr_ok    = we && !clr && w_in_range && !w_zero_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int e = 0; e < DEPTH; e++) begin
                r_mem[e] <= '0;
            end
            r_valid    <= '0;
            r_valid[0] <= (ZERO_REG != 0);
            r_wr_err   <= 1'b0;
        end else begin
            // Error flag is independent of clr: it only reflects the address check.
            r_wr_err <= we && !w_in_range;
            if (clr) begin
                for (int e = 0; e < DEPTH; e++) begin
                    r_mem[e] <= '0;
                end
                r_valid    <= '0;
                r_valid[0] <= (ZERO_REG != 0);
            end else if (w_wr_ok) begin
                for (int e = 0; e < DEPTH; e++) begin
                    if (in_sel == AW'(e)) begin
                        r_mem[e]   <= in_reg;
                        r_valid[e] <= 1'b1;
                    end
                end
            end
        end
    end

    // Per-port read mux; later assignments override earlier ones, so the
    // priority is: array < zero entry < bypass.
    always_comb begin
        for (int p = 0; p < NUM_RD; p++) begin
            w_raw[p]  = '0;
            w_rvld[p] = 1'b0;
            for (int e = 0; e < DEPTH; e++) begin
                if (out_sel[p*AW +: AW] == AW'(e)) begin
                    w_raw[p]  = r_mem[e];
                    w_rvld[p] = r_valid[e];
                end
            end
            if ((ZERO_REG != 0) && (out_sel[p*AW +: AW] == '0)) begin
                w_raw[p]  = '0;
                w_rvld[p] = 1'b1;
            end
            if ((BYPASS != 0) && w_wr_ok && (out_sel[p*AW +: AW] == in_sel)) begin
                w_raw[p]  = in_reg;
                w_rvld[p] = 1'b1;
            end
        end
    end

    genvar p;
    generate
        for (p = 0; p < NUM_RD; p++) begin : g_rd
            if (READ_LAT == 1) begin : g_reg
                logic [DATA_W-1:0] r_out_reg;
                logic              r_out_valid;
                // Captures pre-clear raw data: clr only touches the array at this same edge.
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        r_out_reg   <= '0;
                        r_out_valid <= 1'b0;
                    end else begin
                        r_out_reg   <= w_raw[p];
                        r_out_valid <= w_rvld[p];
                    end
                end
                assign out_reg[p*DATA_W +: DATA_W] = r_out_reg;
                assign out_valid[p]                = r_out_valid;
            end else begin : g_comb
                assign out_reg[p*DATA_W +: DATA_W] = w_raw[p];
                assign out_valid[p]                = w_rvld[p];
            end
        end
    endgenerate

    assign valid_map = r_valid;
    assign wr_err    = r_wr_err;

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: five instances share one stimulus stream
// (default, BYPASS=0, READ_LAT=1, DEPTH=12, ZERO_REG=1) and each is checked
// against hand-computed values.
module tb_reg_file_mp;

    logic       clk = 1'b0;
    logic       rst;
    logic       we;
    logic       clr;
    logic [3:0] in_sel;
    logic [7:0] in_reg;
    logic [7:0] out_sel;

    logic [15:0] o0_reg, o1_reg, o2_reg, o3_reg, o4_reg;
    logic [1:0]  o0_vld, o1_vld, o2_vld, o3_vld, o4_vld;
    logic [15:0] o0_map, o1_map, o2_map, o4_map;
    logic [11:0] o3_map;
    logic        o0_err, o1_err, o2_err, o3_err, o4_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    reg_file_mp u0 (.clk(clk), .rst(rst), .we(we), .in_sel(in_sel), .in_reg(in_reg), .clr(clr),
                    .out_sel(out_sel), .out_reg(o0_reg), .out_valid(o0_vld), .valid_map(o0_map), .wr_err(o0_err));
    reg_file_mp #(.BYPASS(0)) u1 (.clk(clk), .rst(rst), .we(we), .in_sel(in_sel), .in_reg(in_reg), .clr(clr),
                    .out_sel(out_sel), .out_reg(o1_reg), .out_valid(o1_vld), .valid_map(o1_map), .wr_err(o1_err));
    reg_file_mp #(.READ_LAT(1)) u2 (.clk(clk), .rst(rst), .we(we), .in_sel(in_sel), .in_reg(in_reg), .clr(clr),
                    .out_sel(out_sel), .out_reg(o2_reg), .out_valid(o2_vld), .valid_map(o2_map), .wr_err(o2_err));
    reg_file_mp #(.DEPTH(12)) u3 (.clk(clk), .rst(rst), .we(we), .in_sel(in_sel), .in_reg(in_reg), .clr(clr),
                    .out_sel(out_sel), .out_reg(o3_reg), .out_valid(o3_vld), .valid_map(o3_map), .wr_err(o3_err));
    reg_file_mp #(.ZERO_REG(1)) u4 (.clk(clk), .rst(rst), .we(we), .in_sel(in_sel), .in_reg(in_reg), .clr(clr),
                    .out_sel(out_sel), .out_reg(o4_reg), .out_valid(o4_vld), .valid_map(o4_map), .wr_err(o4_err));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; clr = 1'b0;
        in_sel = '0; in_reg = '0; out_sel = '0;
        #12;
        rst = 1'b0;
        // Reset state
        chk("rst_map",      32'(o0_map), 32'h0000);
        chk("rst_vld",      32'(o0_vld), 32'h0);
        chk("rst_lat1_reg", 32'(o2_reg), 32'h0000);
        chk("rst_zero_map", 32'(o4_map), 32'h0001);
        chk("rst_zero_vld", 32'(o4_vld), 32'h3);

        // Write entry 5 with bypass visible before the edge
        we = 1'b1; in_sel = 4'd5; in_reg = 8'h33; out_sel = {4'd5, 4'd5};
        #1;
        chk("byp_pre_reg",    32'(o0_reg), 32'h3333);
        chk("nobyp_pre_vld",  32'(o1_vld), 32'h0);
        tick;
        we = 1'b0;
        chk("wr5_reg",      32'(o0_reg), 32'h3333);
        chk("wr5_lat1_reg", 32'(o2_reg), 32'h3333);
        chk("wr5_lat1_vld", 32'(o2_vld), 32'h3);

        // Mid-cycle reset clears everything immediately
        #1;
        rst = 1'b1;
        #1;
        chk("arst_reg",      32'(o0_reg), 32'h0000);
        chk("arst_vld",      32'(o0_vld), 32'h0);
        chk("arst_map",      32'(o0_map), 32'h0000);
        chk("arst_lat1_reg", 32'(o2_reg), 32'h0000);
        chk("arst_lat1_vld", 32'(o2_vld), 32'h0);
        #1;
        rst = 1'b0;

        // Two-port read of entries 3 and 15
        we = 1'b1; in_sel = 4'd3; in_reg = 8'hA5;
        tick;
        in_sel = 4'd15; in_reg = 8'h5A;
        tick;
        we = 1'b0; out_sel = {4'd15, 4'd3};
        #1;
        chk("rd2_reg",     32'(o0_reg), 32'h5AA5);
        chk("rd2_vld",     32'(o0_vld), 32'h3);
        chk("rd2_map",     32'(o0_map), 32'h8008);
        chk("d12_err15",   32'(o3_err), 32'h1);
        chk("d12_map15",   32'(o3_map), 32'h008);
        out_sel = {4'd4, 4'd3};
        #1;
        chk("rd_unwr_reg", 32'(o0_reg), 32'h00A5);
        chk("rd_unwr_vld", 32'(o0_vld), 32'h1);
        tick;
        chk("d12_err_clr", 32'(o3_err), 32'h0);

        // Bypass vs no bypass on a same-cycle write to entry 7
        we = 1'b1; in_sel = 4'd7; in_reg = 8'h3C; out_sel = {4'd3, 4'd7};
        #1;
        chk("byp_reg",      32'(o0_reg), 32'hA53C);
        chk("byp_vld",      32'(o0_vld), 32'h3);
        chk("nobyp_reg",    32'(o1_reg), 32'hA500);
        chk("nobyp_vld",    32'(o1_vld), 32'h2);
        tick;
        we = 1'b0;
        chk("nobyp_post",   32'(o1_reg), 32'hA53C);
        chk("lat1_byp_cap", 32'(o2_reg), 32'hA53C);

        // Registered read: old value held until the edge
        out_sel = {4'd3, 4'd3};
        #1;
        chk("lat1_hold", 32'(o2_reg), 32'hA53C);
        tick;
        chk("lat1_new",  32'(o2_reg), 32'hA5A5);
        chk("lat1_vld",  32'(o2_vld), 32'h3);

        // Out-of-range write on the 12-deep instance
        we = 1'b1; in_sel = 4'd13; in_reg = 8'hFF; out_sel = {4'd13, 4'd13};
        #1;
        chk("oor_rd_reg", 32'(o3_reg), 32'h0000);
        chk("oor_rd_vld", 32'(o3_vld), 32'h0);
        tick;
        we = 1'b0;
        chk("oor_err",    32'(o3_err), 32'h1);
        chk("oor_map",    32'(o3_map), 32'h088);
        chk("inr_err",    32'(o0_err), 32'h0);
        tick;
        chk("oor_err_1cy", 32'(o3_err), 32'h0);

        // clr beats a same-cycle write; registered read captures pre-clear data
        we = 1'b1; clr = 1'b1; in_sel = 4'd2; in_reg = 8'h11; out_sel = {4'd3, 4'd2};
        tick;
        we = 1'b0; clr = 1'b0;
        chk("clr_reg",      32'(o0_reg), 32'h0000);
        chk("clr_vld",      32'(o0_vld), 32'h0);
        chk("clr_map",      32'(o0_map), 32'h0000);
        chk("clr_lat1_reg", 32'(o2_reg), 32'hA500);
        chk("clr_lat1_vld", 32'(o2_vld), 32'h2);
        chk("clr_zero_map", 32'(o4_map), 32'h0001);

        // Hardwired-zero entry 0
        we = 1'b1; in_sel = 4'd0; in_reg = 8'h77; out_sel = {4'd0, 4'd0};
        #1;
        chk("zero_pre_reg", 32'(o4_reg), 32'h0000);
        chk("zero_pre_vld", 32'(o4_vld), 32'h3);
        tick;
        we = 1'b0;
        chk("zero_reg",  32'(o4_reg), 32'h0000);
        chk("zero_vld",  32'(o4_vld), 32'h3);
        chk("zero_err",  32'(o4_err), 32'h0);
        chk("zero_map",  32'(o4_map), 32'h0001);
        chk("nz_e0_reg", 32'(o0_reg), 32'h7777);
        chk("nz_e0_map", 32'(o0_map), 32'h0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
